// File: rtl/pipe_reg_elastic_pkg.sv
// Shared helpers for the elastic register pipeline.
package pipe_reg_elastic_pkg;

    // Widest pipeline the occupancy helper below is written for.
    localparam int MAX_STAGE = 64;

    // Number of set bits in a stage-valid vector (zero-extended to MAX_STAGE).
    function automatic int unsigned pop_count(input logic [MAX_STAGE-1:0] bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_STAGE; i++) begin
            if (bits[i]) n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_reg_elastic_stage.sv
// One pipeline slot: a valid bit and a data register. The slot loads when
// its load enable is high, holds otherwise, and flush drops the valid bit.
module pipe_reg_elastic_stage
    import pipe_reg_elastic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_flush,
    input  logic             i_v,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_v,
    output logic [WIDTH-1:0] o_d,
    output logic             o_v_nxt
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;
    logic             w_v_nxt;

    // Next valid: flush wins over any load, then load, then hold.
    always_comb begin
        w_v_nxt = r_v;
        if (i_flush) begin
            w_v_nxt = 1'b0;
        end else if (i_load) begin
            w_v_nxt = i_v;
        end
    end

    // Slot registers; data of an empty slot is don't-care but still loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else begin
            r_v <= w_v_nxt;
            if (i_load && !i_flush) begin
                r_d <= i_d;
            end
        end
    end

    assign o_v     = r_v;
    assign o_d     = r_d;
    assign o_v_nxt = w_v_nxt;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic register pipeline of STAGE slots with bubble collapsing.
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high; valid never depends on ready of the same side.
// in_ready is combinational from stage valids, out_ready and flush;
// out_valid/out_data come straight from the last slot's registers.
module pipe_reg_elastic
    import pipe_reg_elastic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STAGE = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(STAGE+1)-1:0] count
);

    localparam int CNT_W = $clog2(STAGE + 1);

    // Index 0 is the input-side slot, index STAGE-1 drives the output.
    logic [STAGE-1:0]            w_v;
    logic [STAGE-1:0]            w_v_nxt;
    logic [STAGE-1:0]            w_rdy;
    logic [STAGE-1:0][WIDTH-1:0] w_d;
    logic                        w_carry;
    logic [CNT_W-1:0]            r_count;

    // Ready ripples back from the output: a slot can load if it is empty
    // or the slot ahead of it is moving.
    always_comb begin
        w_rdy   = '0;
        w_carry = out_ready;
        for (int i = STAGE - 1; i >= 0; i--) begin
            w_carry  = !w_v[i] | w_carry;
            w_rdy[i] = w_carry;
        end
    end

    assign in_ready = w_rdy[0] & ~flush;

    for (genvar g = 0; g < STAGE; g++) begin : g_stage
        if (g == 0) begin : g_first
            pipe_reg_elastic_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_rdy[g]),
                .i_flush (flush),
                .i_v     (in_valid & in_ready),
                .i_d     (in_data),
                .o_v     (w_v[g]),
                .o_d     (w_d[g]),
                .o_v_nxt (w_v_nxt[g])
            );
        end else begin : g_next
            pipe_reg_elastic_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_rdy[g]),
                .i_flush (flush),
                .i_v     (w_v[g-1]),
                .i_d     (w_d[g-1]),
                .o_v     (w_v[g]),
                .o_d     (w_d[g]),
                .o_v_nxt (w_v_nxt[g])
            );
        end
    end

    // Occupancy register tracks the number of valid slots after each edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= CNT_W'(pop_count(MAX_STAGE'(w_v_nxt)));
        end
    end

    assign out_valid = w_v[STAGE-1];
    assign out_data  = w_d[STAGE-1];
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: four instances (STAGE 3, 2, 1, 4; WIDTH 8)
// driven by directed sequences and a seeded random stream, checked by a
// queue-based reference of an ordered buffer holding at most STAGE words.
module tb_pipe_reg_elastic;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [N];
    logic         in_ready  [N];
    logic [W-1:0] in_data   [N];
    logic         out_valid [N];
    logic         out_ready [N];
    logic [W-1:0] out_data  [N];
    logic         flush     [N];
    logic [2:0]   cnt       [N];
    logic [1:0]   cnt0, cnt1;
    logic [0:0]   cnt2;
    logic [2:0]   cnt3;

    logic [W-1:0] exp_q [N][$];
    int           ts_q  [N][$];
    bit           lat_on [N];
    int           cyc = 0;
    int           n_pass = 0;
    int           n_total = 0;

    assign cnt[0] = {1'b0, cnt0};
    assign cnt[1] = {1'b0, cnt1};
    assign cnt[2] = {2'b00, cnt2};
    assign cnt[3] = cnt3;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_reg_elastic #(.WIDTH(W), .STAGE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .flush(flush[0]), .count(cnt0));
    pipe_reg_elastic #(.WIDTH(W), .STAGE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .flush(flush[1]), .count(cnt1));
    pipe_reg_elastic #(.WIDTH(W), .STAGE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .flush(flush[2]), .count(cnt2));
    pipe_reg_elastic #(.WIDTH(W), .STAGE(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_data(out_data[3]), .flush(flush[3]), .count(cnt3));

    function automatic int stg(input int k);
        case (k)
            0:       return 3;
            1:       return 2;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, k, act, exp, $time);
    endtask

    // ---------------- scoreboard monitor ----------------
    // Reference: an ordered buffer of at most STAGE words. Occupancy equals
    // count; the pipe can accept whenever it is not full or the head leaves.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                exp_q[k].delete();
                ts_q[k].delete();
            end else begin
                check("count", k, 32'(cnt[k]), exp_q[k].size());
                check("in_ready", k, 32'(in_ready[k]),
                      32'(!flush[k] && (exp_q[k].size() < stg(k) || out_ready[k])));
                if (exp_q[k].size() == 0) check("out_valid_empty", k, 32'(out_valid[k]), 0);
                else if (out_valid[k]) check("out_data", k, 32'(out_data[k]), 32'(exp_q[k][0]));
                if (out_valid[k] && out_ready[k] && exp_q[k].size() > 0) begin
                    if (lat_on[k]) check("latency", k, cyc - ts_q[k][0], stg(k));
                    void'(exp_q[k].pop_front());
                    void'(ts_q[k].pop_front());
                end
                if (flush[k]) begin
                    exp_q[k].delete();
                    ts_q[k].delete();
                end else if (in_valid[k] && in_ready[k]) begin
                    exp_q[k].push_back(in_data[k]);
                    ts_q[k].push_back(cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [W-1:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready[k];
            tick();
            n++;
        end
        in_valid[k] = 1'b0;
        check("send_accept", k, 32'(acc), 1);
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", k, exp_q[k].size(), 0);
    endtask

    task automatic rand_run(input int k, input int nwords);
        int  acc_n;
        int  cy;
        bit  acc;
        acc_n = 0;
        cy = 0;
        in_valid[k] = 1'b0;
        while (acc_n < nwords && cy < 40000) begin
            if (!in_valid[k] && $urandom_range(3) != 0) begin
                in_valid[k] = 1'b1;
                in_data[k]  = W'($urandom);
            end
            out_ready[k] = ($urandom_range(3) != 0);
            flush[k]     = ($urandom_range(499) == 0);
            @(negedge clk);
            acc = in_valid[k] && in_ready[k];
            tick();
            cy++;
            if (acc || flush[k]) in_valid[k] = 1'b0;
            if (acc) acc_n++;
        end
        flush[k] = 1'b0;
        in_valid[k] = 1'b0;
        check("rand_words", k, acc_n, nwords);
        out_ready[k] = 1'b1;
        drain(k);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        void'($urandom(32'd20240611));
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
            flush[k] = 1'b0; lat_on[k] = 1'b0;
        end
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state of every instance.
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_out_valid", k, 32'(out_valid[k]), 0);
            check("rst_out_data", k, 32'(out_data[k]), 0);
            check("rst_count", k, 32'(cnt[k]), 0);
            check("rst_in_ready", k, 32'(in_ready[k]), 1);
        end
        tick();

        // Back-to-back stream with out_ready high: fixed latency, 1 word/cycle.
        out_ready[0] = 1'b1;
        lat_on[0] = 1'b1;
        for (int i = 1; i <= 10; i++) send(0, W'(i));
        drain(0);
        lat_on[0] = 1'b0;

        // Back-pressure: three words absorbed, fourth refused until release.
        out_ready[0] = 1'b0;
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h44;
        @(negedge clk);
        check("full_in_ready", 0, 32'(in_ready[0]), 0);
        check("full_count", 0, 32'(cnt[0]), 3);
        tick();
        out_ready[0] = 1'b1;
        send(0, 8'h44);
        drain(0);

        // Single word with out_ready toggling on the two-stage instance.
        out_ready[1] = 1'b0;
        fork
            begin
                repeat (12) begin
                    tick();
                    out_ready[1] = !out_ready[1];
                end
            end
            send(1, 8'hAB);
        join
        @(negedge clk);
        check("single_drained", 1, exp_q[1].size(), 0);
        check("single_count", 1, 32'(cnt[1]), 0);
        tick();

        // Flush a full pipe while a word is offered.
        out_ready[0] = 1'b0;
        send(0, 8'hA1);
        send(0, 8'hA2);
        send(0, 8'hA3);
        flush[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h55;
        @(negedge clk);
        check("flush_in_ready", 0, 32'(in_ready[0]), 0);
        tick();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 0, 32'(out_valid[0]), 0);
        check("flush_count", 0, 32'(cnt[0]), 0);
        out_ready[0] = 1'b1;
        repeat (6) tick();

        // Reset with two words in flight, then a clean stream.
        out_ready[0] = 1'b0;
        send(0, 8'h61);
        send(0, 8'h62);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 0, 32'(out_valid[0]), 0);
        check("midrst_out_data", 0, 32'(out_data[0]), 0);
        check("midrst_count", 0, 32'(cnt[0]), 0);
        tick();
        out_ready[0] = 1'b1;
        lat_on[0] = 1'b1;
        for (int i = 0; i < 4; i++) send(0, W'(8'h71 + i));
        drain(0);
        lat_on[0] = 1'b0;

        // Random valid/ready/flush on the one- and four-stage instances.
        fork
            rand_run(2, 10000);
            rand_run(3, 10000);
        join
        repeat (4) tick();

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_reg_elastic.md
PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits, SHALL be >= 1.
REQ-002 Parameter STAGE, default 2: number of register stages, SHALL be >= 1.
REQ-003 Localparam CNT_W = $clog2(STAGE+1): width of the occupancy count.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-006 in_valid  input  1  upstream data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  pipe[STAGE] holds valid data.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  payload of the last stage.
REQ-012 flush  input  1  discard all in-flight data.
REQ-013 count  output  CNT_W  number of stages currently holding valid data.

Function
REQ-014 Each stage i (1..STAGE) SHALL hold a valid bit v[i] and a WIDTH-bit data register d[i].
REQ-015 Stage ready SHALL be rdy[i] = !v[i] | rdy[i+1], with rdy[STAGE+1] = out_ready (bubble-collapsing, combinational).
REQ-016 in_ready SHALL equal rdy[1] & !flush.
REQ-017 Transfer in: when in_valid & in_ready, d[1] <= in_data and v[1] <= 1 at the next edge.
REQ-018 Stage i>1 SHALL load d[i-1], v[i-1] when rdy[i]=1, otherwise hold.
REQ-019 Stage 1 SHALL load v[1] <= in_valid & in_ready when rdy[1]=1, otherwise hold.
REQ-020 A stage whose valid is 0 SHALL still be overwritable; its data is don't-care but SHALL never be presented with out_valid=1.
REQ-021 out_valid = v[STAGE] and out_data = d[STAGE], both directly from registers.
REQ-022 Latency with out_ready held 1: a word accepted at edge t SHALL appear on out_data after edge t+STAGE-1, i.e. valid during cycle t+STAGE.
REQ-023 Throughput SHALL be one word per cycle when out_ready is held 1.
REQ-024 Back-pressure: with out_ready=0 and all stages full, in_ready SHALL be 0 and every stage SHALL hold; no data lost or duplicated.
REQ-025 Partial stall: with out_ready=0, empty stages SHALL still fill, so up to STAGE words are absorbed before in_ready drops.
REQ-026 Flush SHALL clear all v[i] at the next edge; the input word offered in the flush cycle SHALL be discarded (in_ready=0).
REQ-027 Flush and out_ready in the same cycle: the output word SHALL count as consumed; flush has priority over all loads.
REQ-028 count SHALL be registered, equal to the sum of v[i] after each edge, range 0..STAGE.
REQ-029 Order of words SHALL be preserved.

Reset
REQ-030 rst_n=0 at a posedge SHALL clear all v[i], all d[i] to 0, and count to 0.
REQ-031 After reset, out_valid=0 and out_data=0; in_ready=1 once rst_n=1 and flush=0.
REQ-032 Reset mid-operation SHALL drop all in-flight words; no output is produced for them.

Structure
REQ-033 No shared package is required; CNT_W is local to the module.
REQ-034 One sub-module, pipe_reg_elastic_stage (v/d register pair with load enable and flush), SHALL be instantiated STAGE times via generate.

Verification
REQ-035 STAGE=3, WIDTH=8, out_ready=1, stream 0x01..0x0A back-to-back -> out_data 0x01..0x0A on consecutive cycles, first one 3 cycles after acceptance.
REQ-036 STAGE=3, out_ready=0, offer 0x11,0x22,0x33,0x44 -> first three accepted, in_ready=0 on 0x44, count=3; raise out_ready -> 0x11,0x22,0x33,0x44 in order.
REQ-037 STAGE=2, single word 0xAB then bubble, out_ready toggling 0/1 each cycle -> 0xAB emitted exactly once, count returns to 0.
REQ-038 STAGE=3, pipe full, assert flush with in_valid=1 data 0x55 -> next cycle out_valid=0, count=0, 0x55 never emitted.
REQ-039 Assert rst_n=0 for one cycle with 2 words in flight -> out_valid=0, out_data=0, count=0; subsequent stream starts cleanly.
REQ-040 Random valid/ready (seeded), STAGE in {1,4}: scoreboard confirms no loss, duplication or reordering over 10000 words.
